fanout_valid_fork: RTL and testbench
====================================

# fanout_valid_fork

Registered valid-side fork for the CGRA interconnect. It broadcasts one upstream token to up to NUM_OUT consumer tracks. The destination set is taken per track from the route enable and select bit. Each consumer handshakes independently (eager fork), and the upstream is released only after every selected consumer has accepted the token. It sits at a switch-box fanout point and is the valid/data counterpart of the combinational ready-aggregation logic for the same fanout.

## Interface
- NUM_OUT, 20, number of consumer tracks
- DATA_W, 16, token data width
- SEL_W, 8, width of each per-track select field
- SEL_BIT, 5, bit of the select field that routes the track to this fork
- CLK  input  1  clock, all state updates on rising edge
- ASYNCRESET  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream token valid
- in_data  input  DATA_W  upstream token data
- in_ready  output  1  fork can accept a token this cycle
- E  input  NUM_OUT  per-track route enable
- S  input  NUM_OUT*SEL_W  per-track select fields, track i at [i*SEL_W +: SEL_W]
- out_valid  output  NUM_OUT  per-track token valid
- out_data  output  DATA_W  buffered token data, shared by all tracks
- out_ready  input  NUM_OUT  per-track consumer ready
- clr  input  1  synchronous clear of buffer and counters
- tok_count  output  16  tokens fully delivered, wraps
- drop_count  output  16  tokens accepted with an empty destination set, wraps

## Operation
- State: full (1b), data_q (DATA_W), pend (NUM_OUT), tok_count, drop_count.
- dest[i] = E[i] & S[i][SEL_BIT], evaluated combinationally at capture time only.
- out_valid[i] = full & pend[i].
- out_data = data_q.
- xfer[i] = out_valid[i] & out_ready[i].
- rem = pend & ~xfer.
- last = full & (rem == 0).
- in_ready = ~full | last. A new token may enter in the same cycle the current token completes.
- Capture: when in_valid & in_ready and dest != 0, set data_q <= in_data, pend <= dest, full <= 1.
- Empty destination: when in_valid & in_ready and dest == 0, the token is consumed and discarded. drop_count increments, and full becomes 0 if last was set, otherwise stays 0.
- Per cycle with no capture: pend <= rem. When last is set, full <= 0 and tok_count increments.
- Completion and capture in the same cycle: tok_count increments, and the new token overwrites data_q/pend with full staying 1.
- Destination set is latched: changes to E/S while full do not alter pend. The new routing applies from the next capture.
- A track that has accepted never sees out_valid again for the same token, even if its ready stays high.
- clr (sync, overrides all other updates): full <= 0, pend <= 0, counters <= 0. in_ready is still computed from the pre-clear state in that cycle, but no capture occurs.
- Counters wrap 0xFFFF -> 0x0000.
- States (encoded by full): EMPTY, then HOLD on capture with nonzero dest. HOLD returns to EMPTY on last with no new capture, or stays in HOLD on last with a new capture.

## Timing
- Reset values: full=0, pend=0, data_q=0, out_valid=0, out_data=0, in_ready=1, tok_count=0, drop_count=0.
- ASYNCRESET asserted mid-token discards the token immediately with no delivery. Outputs take their reset values without waiting for a clock edge.
- Latency: 1 cycle from upstream acceptance to out_valid on the destination tracks.
- Throughput: 1 token/cycle when all selected consumers are ready every cycle.
- in_ready depends combinationally on out_ready and must be free of loops from in_valid.
- out_valid, out_data, tok_count and drop_count are driven from registers only.
- A valid token must not be dropped while any pend bit is set.

## Test plan
- Reset, then send data 0x1234 with dest={0,3} and both tracks always ready. Expect out_valid=0x00009 one cycle later, in_ready=1 throughout, tok_count=1 after completion.
- Send dest={1,2,7}. Track 1 accepts at cycle 1, track 7 at cycle 3, track 2 at cycle 5. Expect out_valid bits to clear individually, in_ready=0 in cycles 1-4, in_ready=1 in cycle 5, and back-to-back capture of the next token in cycle 5.
- Set all E=0 and send 3 tokens. Expect drop_count=3, tok_count=0, out_valid never asserted.
- With a token pending to track 4, flip E[4]=0 and E[5]=1. Expect delivery still on track 4 only. The next token goes to track 5.
- Stream 70000 single-destination tokens with the consumer always ready. Expect tok_count=70000 mod 65536=4464 and throughput 1/cycle.
- Assert ASYNCRESET between clock edges while pend=0x00003. Expect out_valid=0 and in_ready=1 immediately, and no delivery after release. Separately, pulse clr while full: expect counters=0 and full=0 on the next cycle.

Source files
------------

// File: rtl/fanout_valid_fork.sv
// Registered eager fork: broadcasts one upstream token to the routed consumer tracks
// and releases upstream once every selected track has taken it.
module fanout_valid_fork #(
    parameter int NUM_OUT = 20,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 8,
    parameter int SEL_BIT = 5
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [NUM_OUT-1:0]       E,
    input  logic [NUM_OUT*SEL_W-1:0] S,
    output logic [NUM_OUT-1:0]       out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic [NUM_OUT-1:0]       out_ready,
    input  logic                     clr,
    output logic [15:0]              tok_count,
    output logic [15:0]              drop_count
);

    logic                r_full;
    logic [DATA_W-1:0]   r_data;
    logic [NUM_OUT-1:0]  r_pend;
    logic [15:0]         r_tok;
    logic [15:0]         r_drop;

    logic [NUM_OUT-1:0]  w_dest;
    logic [NUM_OUT-1:0]  w_xfer;
    logic [NUM_OUT-1:0]  w_rem;
    logic                w_last;
    logic                w_acc;
    logic                w_unused_sel;

    // Only one bit of each select field routes to this fork.
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_dest
        assign w_dest[i] = E[i] & S[i*SEL_W + SEL_BIT];
    end
    assign w_unused_sel = ^S;

    assign out_valid = {NUM_OUT{r_full}} & r_pend;
    assign out_data  = r_data;
    assign w_xfer    = out_valid & out_ready;
    assign w_rem     = r_pend & ~w_xfer;
    assign w_last    = r_full & (w_rem == '0);
    assign in_ready  = ~r_full | w_last;
    assign w_acc     = in_valid & in_ready;

    assign tok_count  = r_tok;
    assign drop_count = r_drop;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_pend <= '0;
            r_tok  <= '0;
            r_drop <= '0;
        end else if (clr) begin
            r_full <= 1'b0;
            r_pend <= '0;
            r_tok  <= '0;
            r_drop <= '0;
        end else begin
            if (w_last)
                r_tok <= r_tok + 16'd1;
            // A new token may overwrite the buffer in the cycle the old one completes.
            if (w_acc && (w_dest != '0)) begin
                r_data <= in_data;
                r_pend <= w_dest;
                r_full <= 1'b1;
            end else begin
                r_pend <= w_rem;
                if (w_last)
                    r_full <= 1'b0;
                if (w_acc)
                    r_drop <= r_drop + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fanout_valid_fork.sv
// Bench for fanout_valid_fork: directed vector table, hand sequences for reset/clr/wrap,
// and randomized traffic against a per-track behavioural model.
module tb_fanout_valid_fork;
    localparam int NUM_OUT = 20;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 8;
    localparam int SEL_BIT = 5;
    localparam int SW      = NUM_OUT * SEL_W;

    logic                CLK = 1'b0;
    logic                ASYNCRESET;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic [NUM_OUT-1:0]  E;
    logic [SW-1:0]       S;
    logic [NUM_OUT-1:0]  out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [NUM_OUT-1:0]  out_ready;
    logic                clr;
    logic [15:0]         tok_count;
    logic [15:0]         drop_count;

    fanout_valid_fork #(
        .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .SEL_W(SEL_W), .SEL_BIT(SEL_BIT)
    ) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .E(E), .S(S),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .clr(clr), .tok_count(tok_count), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic                v;
        logic [DATA_W-1:0]   d;
        logic [NUM_OUT-1:0]  e;
        logic [SW-1:0]       s;
        logic [NUM_OUT-1:0]  rdy;
        logic [NUM_OUT-1:0]  x_ov;
        logic                x_ir;
        logic [DATA_W-1:0]   x_dat;
        logic [15:0]         x_tok;
        logic [15:0]         x_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [DATA_W-1:0] d, logic [NUM_OUT-1:0] e,
                                logic [SW-1:0] s, logic [NUM_OUT-1:0] rdy,
                                logic [NUM_OUT-1:0] x_ov, logic x_ir, logic [DATA_W-1:0] x_dat,
                                logic [15:0] x_tok, logic [15:0] x_drop);
        vec_t r;
        r.v = v; r.d = d; r.e = e; r.s = s; r.rdy = rdy;
        r.x_ov = x_ov; r.x_ir = x_ir; r.x_dat = x_dat; r.x_tok = x_tok; r.x_drop = x_drop;
        return r;
    endfunction

    task automatic drv(input logic v, input logic [DATA_W-1:0] d, input logic [NUM_OUT-1:0] e,
                       input logic [SW-1:0] s, input logic [NUM_OUT-1:0] r);
        in_valid = v; in_data = d; E = e; S = s; out_ready = r;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Behavioural model: one buffered token and the list of tracks still owed it.
    bit                 m_full;
    logic [DATA_W-1:0]  m_data;
    bit                 m_left [NUM_OUT];
    int                 m_tok;
    int                 m_drop;

    initial begin
        logic [SW-1:0]      s_all;
        logic [SW-1:0]      s_t6;
        logic [NUM_OUT-1:0] ones;
        int                 stalls;
        int                 seen;

        s_all = '1;
        s_t6  = '0;
        s_t6[6*SEL_W + SEL_BIT] = 1'b1;
        ones  = '1;

        clr = 1'b0;
        drv(1'b0, '0, '0, '0, '0);
        ASYNCRESET = 1'b1;
        #12;
        ASYNCRESET = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_data", out_data, 0);
        chk("reset tok_count", tok_count, 0);
        chk("reset drop_count", drop_count, 0);
        tick();

        // two-track broadcast, always ready
        tbl.push_back(mk(1, 16'h1234, 20'h00009, s_all, ones, 20'h0,     1, 16'h0,    0, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00009, s_all, ones, 20'h00009, 1, 16'h1234, 0, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00009, s_all, ones, 20'h0,     1, 16'h0,    1, 0));
        // staggered acceptance on tracks 1,2,7 with back-to-back capture
        tbl.push_back(mk(1, 16'hA5A5, 20'h00086, s_all, 20'h0,     20'h0,     1, 16'h0,    1, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00086, s_all, 20'h00002, 20'h00086, 0, 16'hA5A5, 1, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00086, s_all, 20'h0,     20'h00084, 0, 16'hA5A5, 1, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00086, s_all, 20'h00080, 20'h00084, 0, 16'hA5A5, 1, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00086, s_all, 20'h0,     20'h00004, 0, 16'hA5A5, 1, 0));
        tbl.push_back(mk(1, 16'h5A5A, 20'h00001, s_all, 20'h00004, 20'h00004, 1, 16'hA5A5, 1, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00001, s_all, ones,      20'h00001, 1, 16'h5A5A, 2, 0));
        tbl.push_back(mk(0, 16'h0,    20'h00001, s_all, ones,      20'h0,     1, 16'h0,    3, 0));
        // empty destination set: three drops
        tbl.push_back(mk(1, 16'h0D01, 20'h0, s_all, ones, 20'h0, 1, 16'h0, 3, 0));
        tbl.push_back(mk(1, 16'h0D02, 20'h0, s_all, ones, 20'h0, 1, 16'h0, 3, 1));
        tbl.push_back(mk(1, 16'h0D03, 20'h0, s_all, ones, 20'h0, 1, 16'h0, 3, 2));
        tbl.push_back(mk(0, 16'h0,    20'h0, s_all, ones, 20'h0, 1, 16'h0, 3, 3));
        // routing is latched at capture
        tbl.push_back(mk(1, 16'h0444, 20'h00010, s_all, 20'h0, 20'h0,     1, 16'h0,    3, 3));
        tbl.push_back(mk(0, 16'h0,    20'h00020, s_all, 20'h0, 20'h00010, 0, 16'h0444, 3, 3));
        tbl.push_back(mk(0, 16'h0,    20'h00020, s_all, ones,  20'h00010, 1, 16'h0444, 3, 3));
        tbl.push_back(mk(1, 16'h0555, 20'h00020, s_all, ones,  20'h0,     1, 16'h0,    4, 3));
        tbl.push_back(mk(0, 16'h0,    20'h00020, s_all, ones,  20'h00020, 1, 16'h0555, 4, 3));
        tbl.push_back(mk(0, 16'h0,    20'h00020, s_all, ones,  20'h0,     1, 16'h0,    5, 3));
        // select bit gates the enable: only track 6 has it set
        tbl.push_back(mk(1, 16'h0666, ones, s_t6, ones, 20'h0,     1, 16'h0,    5, 3));
        tbl.push_back(mk(0, 16'h0,    ones, s_t6, ones, 20'h00040, 1, 16'h0666, 5, 3));
        tbl.push_back(mk(0, 16'h0,    ones, s_t6, ones, 20'h0,     1, 16'h0,    6, 3));

        for (int k = 0; k < tbl.size(); k++) begin
            drv(tbl[k].v, tbl[k].d, tbl[k].e, tbl[k].s, tbl[k].rdy);
            @(negedge CLK);
            chk($sformatf("vec%0d out_valid", k), out_valid, tbl[k].x_ov);
            chk($sformatf("vec%0d in_ready", k), in_ready, tbl[k].x_ir);
            chk($sformatf("vec%0d tok_count", k), tok_count, tbl[k].x_tok);
            chk($sformatf("vec%0d drop_count", k), drop_count, tbl[k].x_drop);
            if (tbl[k].x_ov != '0)
                chk($sformatf("vec%0d out_data", k), out_data, tbl[k].x_dat);
            tick();
        end

        // asynchronous reset in the middle of a held token
        drv(1, 16'h7777, 20'h00003, s_all, '0);
        tick();
        in_valid = 1'b0;
        @(negedge CLK);
        chk("arst pre out_valid", out_valid, 20'h00003);
        #1 ASYNCRESET = 1'b1;
        #1;
        chk("arst out_valid", out_valid, 0);
        chk("arst in_ready", in_ready, 1);
        chk("arst out_data", out_data, 0);
        chk("arst tok_count", tok_count, 0);
        #1 ASYNCRESET = 1'b0;
        out_ready = '1;
        seen = 0;
        repeat (3) begin
            @(negedge CLK);
            if (out_valid != '0) seen++;
        end
        chk("arst no delivery", seen, 0);
        chk("arst tok after", tok_count, 0);
        tick();

        // synchronous clear while full
        drv(1, 16'h0C00, 20'h0, s_all, ones);
        tick();
        drv(1, 16'h0C01, 20'h00001, s_all, ones);
        tick();
        drv(1, 16'h0C02, 20'h00002, s_all, 20'h00001);
        tick();
        drv(1, 16'h0C03, 20'h00004, s_all, '0);
        clr = 1'b1;
        @(negedge CLK);
        chk("clr pre in_ready", in_ready, 0);
        chk("clr pre out_valid", out_valid, 20'h00002);
        chk("clr pre tok_count", tok_count, 1);
        chk("clr pre drop_count", drop_count, 1);
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("clr out_valid", out_valid, 0);
        chk("clr in_ready", in_ready, 1);
        chk("clr tok_count", tok_count, 0);
        chk("clr drop_count", drop_count, 0);
        tick();

        // 70000-token stream exercises counter wrap and full throughput
        drv(1, 16'h00AA, 20'h00001, s_all, ones);
        stalls = 0;
        repeat (70000) begin
            @(negedge CLK);
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        @(negedge CLK);
        chk("stream stalls", stalls, 0);
        chk("stream tok wrap", tok_count, 16'd4464);
        chk("stream drop", drop_count, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        m_full = 0; m_data = '0; m_tok = 0; m_drop = 0;
        for (int i = 0; i < NUM_OUT; i++) m_left[i] = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NUM_OUT-1:0] x_ov;
            bit                 all_taken;
            bit                 any_dest;
            bit                 x_ir;
            int                 mode;

            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = DATA_W'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0: E = '0;
                1: E = NUM_OUT'(1) << $urandom_range(0, NUM_OUT - 1);
                default: E = NUM_OUT'($urandom);
            endcase
            for (int i = 0; i < NUM_OUT; i++) S[i*SEL_W +: SEL_W] = SEL_W'($urandom);
            mode = $urandom_range(0, 2);
            case (mode)
                0: out_ready = '1;
                1: out_ready = NUM_OUT'($urandom);
                default: out_ready = NUM_OUT'($urandom & $urandom);
            endcase
            clr = ($urandom_range(0, 63) == 0);

            @(negedge CLK);
            all_taken = 1;
            for (int i = 0; i < NUM_OUT; i++) begin
                x_ov[i] = m_full && m_left[i];
                if (m_left[i] && !out_ready[i]) all_taken = 0;
            end
            x_ir = !m_full || all_taken;
            chk($sformatf("rnd%0d out_valid", cyc), out_valid, x_ov);
            chk($sformatf("rnd%0d in_ready", cyc), in_ready, x_ir);
            chk($sformatf("rnd%0d tok_count", cyc), tok_count, m_tok % 65536);
            chk($sformatf("rnd%0d drop_count", cyc), drop_count, m_drop % 65536);
            if (m_full)
                chk($sformatf("rnd%0d out_data", cyc), out_data, m_data);

            if (clr) begin
                m_full = 0; m_tok = 0; m_drop = 0;
                for (int i = 0; i < NUM_OUT; i++) m_left[i] = 0;
            end else begin
                if (m_full && all_taken) begin
                    m_tok++;
                    m_full = 0;
                end
                for (int i = 0; i < NUM_OUT; i++)
                    if (out_ready[i]) m_left[i] = 0;
                if (in_valid && x_ir) begin
                    any_dest = 0;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        m_left[i] = E[i] && S[i*SEL_W + SEL_BIT];
                        if (m_left[i]) any_dest = 1;
                    end
                    if (any_dest) begin
                        m_full = 1;
                        m_data = in_data;
                    end else begin
                        m_drop++;
                    end
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
